exec_sequencer: RTL and testbench
=================================

// Module: exec_sequencer
// PURPOSE
//  Run/step sequencer between the debug unit and the pipeline. Gates pipeline
//  advance (o_cpu_enable; pc_control i_halt = ~o_cpu_enable) and issues
//  pipeline flushes. It tracks retired-HALT completion and counts executed cycles.
//  Sits between the debug command path and the CPU top.
// PARAMETERS
//  CYCLE_CNT_W  32  width of executed-cycle counter
// PORTS
//  i_clk           in   1            clock
//  i_reset         in   1            synchronous, active-high reset
//  i_cmd_valid     in   1            command valid
//  i_cmd           in   2            00 FLUSH, 01 RUN, 10 STEP, 11 STOP
//  o_cmd_ready     out  1            command accepted when valid&&ready at posedge
//  i_halt_retired  in   1            HALT instruction in WB this cycle
//  i_pc            in   32           current fetch PC (breakpoint compare only)
//  o_cpu_enable    out  1            pipeline/PC advance enable
//  o_pipe_flush    out  1            1-cycle synchronous pipeline clear pulse
//  o_done          out  1            1-cycle pulse: step finished / HALT / breakpoint
//  o_state         out  2            00 IDLE, 01 RUN, 10 STEP, 11 DONE
//  o_cycle_count   out  CYCLE_CNT_W  cycles with o_cpu_enable=1 since last FLUSH
// BEHAVIOUR
//  - Reset: state IDLE, o_cpu_enable 0, o_pipe_flush 0, o_done 0, count 0,
//    o_cmd_ready 1. Reset mid-RUN/STEP: IDLE next cycle, no o_done pulse.
//  - o_cpu_enable is combinational: 1 in RUN and STEP, else 0. Accept at edge N ->
//    enable high in cycle N+1.
//  - o_cmd_ready: 1 in IDLE, RUN, DONE; 0 in STEP.
//  - IDLE: RUN->RUN; STEP->STEP; FLUSH->o_pipe_flush=1 next cycle, count=0, stay IDLE.
//    STOP is accepted with no effect.
//  - RUN: STOP->IDLE (no o_done). i_halt_retired while enabled->DONE and o_done.
//    If STOP and halt coincide, DONE wins. RUN/STEP/FLUSH: accepted, no effect.
//  - STEP: exactly one enabled cycle, then IDLE with o_done. If i_halt_retired
//    in that cycle, go to DONE (single o_done pulse).
//  - DONE: enable 0. FLUSH->IDLE with flush pulse and count=0. Others accepted, ignored.
//  - Count: +1 per cycle with o_cpu_enable=1. Saturates at all-ones (no wrap).
//  - i_halt_retired is ignored while o_cpu_enable=0.
//  - o_done and o_pipe_flush are registered and high for exactly one cycle.
// CONFIGURATION
//  EXEC_SEQ_BREAKPOINT_EN defined: adds ports i_bp_valid (1), i_bp_addr (32),
//   o_bp_hit (1).
//   - In RUN, hit = i_bp_valid && i_pc==i_bp_addr && armed. On hit: enable=0
//     that cycle (combinational), IDLE next cycle, o_done pulse, o_bp_hit=1.
//   - o_bp_hit is sticky and clears on next accepted command. Reset value 0.
//   - armed clears on entry to RUN and sets after the first enabled cycle, so
//     resuming from a breakpoint advances past it. Halt beats hit when both occur.
//  Not defined: no breakpoint ports or logic; i_pc is unused.
// TESTING
//  1 reset; RUN; halt_retired 10 cycles after enable -> DONE, o_done 1 pulse,
//    count=10 or 11 (incl. halt cycle, 11).
//  2 IDLE; STEP x3 -> 3 single enable pulses, 3 o_done pulses, count=3,
//    ready=0 during each STEP.
//  3 RUN; STOP and halt_retired same cycle -> DONE, o_done=1.
//  4 DONE; RUN -> ignored; FLUSH -> o_pipe_flush 1 cycle, count=0, state IDLE.
//  5 Force count to all-ones-1; RUN 3 cycles -> count holds at all-ones.
//  6 (BREAKPOINT_EN) bp=0x20; RUN; i_pc hits 0x20 -> enable 0, o_bp_hit=1;
//    RUN again -> advances past 0x20.

Source files
------------

// File: rtl/exec_sequencer.sv
// exec_sequencer: run/step sequencer between the debug command path and the CPU.
// It gates pipeline advance, issues pipeline flushes, tracks HALT retirement and
// counts the executed cycles.
//
// Optional feature: define EXEC_SEQ_BREAKPOINT_EN to add a single PC breakpoint
// (ports i_bp_valid, i_bp_addr, o_bp_hit). Without it, i_pc is unused.
//
// Ports:
//   i_clk, i_reset    clock, synchronous active-high reset
//   i_cmd_valid/i_cmd command handshake (00 FLUSH, 01 RUN, 10 STEP, 11 STOP)
//   o_cmd_ready       high in IDLE/RUN/DONE, low in STEP
//   i_halt_retired    HALT in WB this cycle (ignored unless RUN/STEP)
//   i_pc              current fetch PC (breakpoint compare only)
//   o_cpu_enable      pipeline/PC advance enable (decoded from state)
//   o_pipe_flush      one-cycle pipeline clear pulse
//   o_done            one-cycle pulse: step finished / HALT / breakpoint
//   o_state           00 IDLE, 01 RUN, 10 STEP, 11 DONE
//   o_cycle_count     saturating count of enabled cycles since last FLUSH
module exec_sequencer #(
  parameter int unsigned CYCLE_CNT_W = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_cmd_valid,
  input  logic [1:0]             i_cmd,
  output logic                   o_cmd_ready,
  input  logic                   i_halt_retired,
  input  logic [31:0]            i_pc,
  output logic                   o_cpu_enable,
  output logic                   o_pipe_flush,
  output logic                   o_done,
  output logic [1:0]             o_state,
  output logic [CYCLE_CNT_W-1:0] o_cycle_count
`ifdef EXEC_SEQ_BREAKPOINT_EN
  ,
  input  logic                   i_bp_valid,
  input  logic [31:0]            i_bp_addr,
  output logic                   o_bp_hit
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_DONE = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    CMD_FLUSH = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_STOP  = 2'b11
  } cmd_t;

  localparam logic [CYCLE_CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  cmd_t   cmd;
  logic   run_or_step;
  logic   accept;
  logic   halt_evt;
  logic   bp_hit_c;
  logic   bp_take;

  assign cmd         = cmd_t'(i_cmd);
  assign run_or_step = (state == S_RUN) || (state == S_STEP);
  assign o_cmd_ready = (state != S_STEP);
  assign accept      = i_cmd_valid && o_cmd_ready;
  // A retiring HALT is honoured in RUN/STEP even when a breakpoint stalls fetch,
  // so halt takes priority over a coincident breakpoint hit.
  assign halt_evt    = i_halt_retired && run_or_step;
  assign bp_take     = bp_hit_c && !halt_evt;
  assign o_cpu_enable = run_or_step && !bp_hit_c;
  assign o_state     = state;

`ifdef EXEC_SEQ_BREAKPOINT_EN
  logic armed;

  // armed is cleared on entering RUN so a resume starts past the breakpoint PC.
  assign bp_hit_c = (state == S_RUN) && i_bp_valid && (i_pc == i_bp_addr) && armed;

  // Breakpoint arming and sticky hit flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      armed    <= 1'b0;
      o_bp_hit <= 1'b0;
    end else begin
      if (state == S_IDLE && accept && cmd == CMD_RUN) begin
        armed <= 1'b0;
      end else if (state == S_RUN && o_cpu_enable) begin
        armed <= 1'b1;
      end
      if (bp_take) begin
        o_bp_hit <= 1'b1;
      end else if (accept) begin
        o_bp_hit <= 1'b0;
      end
    end
  end
`else
  logic unused_pc;

  assign bp_hit_c  = 1'b0;
  assign unused_pc = ^i_pc;
`endif

  // Sequencer state, pulses and cycle counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= S_IDLE;
      o_pipe_flush  <= 1'b0;
      o_done        <= 1'b0;
      o_cycle_count <= '0;
    end else begin
      o_pipe_flush <= 1'b0;
      o_done       <= 1'b0;
      if (o_cpu_enable && (o_cycle_count != CNT_MAX)) begin
        o_cycle_count <= o_cycle_count + CYCLE_CNT_W'(1);
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (cmd)
              CMD_RUN:  state <= S_RUN;
              CMD_STEP: state <= S_STEP;
              CMD_FLUSH: begin
                o_pipe_flush  <= 1'b1;
                o_cycle_count <= '0;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (halt_evt) begin
            state  <= S_DONE;
            o_done <= 1'b1;
          end else if (bp_take) begin
            state  <= S_IDLE;
            o_done <= 1'b1;
          end else if (accept && cmd == CMD_STOP) begin
            state <= S_IDLE;
          end
        end
        S_STEP: begin
          // Exactly one enabled cycle, then report completion.
          state  <= halt_evt ? S_DONE : S_IDLE;
          o_done <= 1'b1;
        end
        S_DONE: begin
          if (accept && cmd == CMD_FLUSH) begin
            state         <= S_IDLE;
            o_pipe_flush  <= 1'b1;
            o_cycle_count <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed scenarios plus randomized
// traffic compared each cycle against a rule-level model of the sequencer.
// A narrow counter width keeps saturation reachable in a short run.
module tb_exec_sequencer;

  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] CMAX = '1;

  localparam logic [1:0] C_FLUSH = 2'b00;
  localparam logic [1:0] C_RUN   = 2'b01;
  localparam logic [1:0] C_STEP  = 2'b10;
  localparam logic [1:0] C_STOP  = 2'b11;

  localparam logic [1:0] M_IDLE = 2'b00;
  localparam logic [1:0] M_RUN  = 2'b01;
  localparam logic [1:0] M_STEP = 2'b10;
  localparam logic [1:0] M_DONE = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic [1:0]    cmd;
  logic          halt_ret;
  logic [31:0]   pc;
  logic          bp_valid;
  logic [31:0]   bp_addr;
  logic          d_ready, d_en, d_flush, d_done;
  logic [1:0]    d_state;
  logic [CW-1:0] d_cnt;
  logic          d_bphit;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: what the sequencer is doing, by the behavioural rules.
  logic [1:0]    ms;
  logic [CW-1:0] mcnt;
  logic          mflush, mdone, mbphit, marmed;

  exec_sequencer #(.CYCLE_CNT_W(CW)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_cmd_valid    (cmd_valid),
    .i_cmd          (cmd),
    .o_cmd_ready    (d_ready),
    .i_halt_retired (halt_ret),
    .i_pc           (pc),
    .o_cpu_enable   (d_en),
    .o_pipe_flush   (d_flush),
    .o_done         (d_done),
    .o_state        (d_state),
    .o_cycle_count  (d_cnt)
`ifdef EXEC_SEQ_BREAKPOINT_EN
    ,
    .i_bp_valid     (bp_valid),
    .i_bp_addr      (bp_addr),
    .o_bp_hit       (d_bphit)
`endif
  );

`ifndef EXEC_SEQ_BREAKPOINT_EN
  assign d_bphit = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic m_hit();
`ifdef EXEC_SEQ_BREAKPOINT_EN
    return (ms == M_RUN) && bp_valid && (pc == bp_addr) && marmed;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_active();
    return (ms == M_RUN) || (ms == M_STEP);
  endfunction

  function automatic logic m_en();
    return m_active() && !m_hit();
  endfunction

  function automatic logic m_ready();
    return ms != M_STEP;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic en, hit, acc, hv;
    en  = m_en();
    hit = m_hit();
    acc = cmd_valid && m_ready();
    hv  = halt_ret && m_active();
    if (rst) begin
      ms = M_IDLE; mcnt = '0; mflush = 0; mdone = 0; mbphit = 0; marmed = 0;
    end else begin
      mflush = 0;
      mdone  = 0;
      if (en && mcnt != CMAX) mcnt = mcnt + CW'(1);
      if (acc) mbphit = 0;
      if (ms == M_RUN && en) marmed = 1;
      case (ms)
        M_IDLE: if (acc) begin
          if (cmd == C_RUN) begin ms = M_RUN; marmed = 0; end
          else if (cmd == C_STEP) ms = M_STEP;
          else if (cmd == C_FLUSH) begin mflush = 1; mcnt = '0; end
        end
        M_RUN: begin
          if (hv) begin ms = M_DONE; mdone = 1; end
          else if (hit) begin ms = M_IDLE; mdone = 1; mbphit = 1; end
          else if (acc && cmd == C_STOP) ms = M_IDLE;
        end
        M_STEP: begin ms = hv ? M_DONE : M_IDLE; mdone = 1; end
        default: if (acc && cmd == C_FLUSH) begin ms = M_IDLE; mflush = 1; mcnt = '0; end
      endcase
    end
  endtask

  task automatic apply(input logic v, input logic [1:0] c, input logic h);
    cmd_valid = v;
    cmd       = c;
    halt_ret  = h;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply(0, C_FLUSH, 0);
    apply(1, C_RUN, 1);
    n_vec++; if (d_state !== M_IDLE) begin n_err++; $display("FAIL reset_state got %0d want 0", d_state); end
    n_vec++; if (d_en !== 1'b0) begin n_err++; $display("FAIL reset_enable got %b want 0", d_en); end
    n_vec++; if (d_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", d_ready); end
    n_vec++; if (d_flush !== 1'b0 || d_done !== 1'b0) begin n_err++; $display("FAIL reset_pulses got flush=%b done=%b want 0/0", d_flush, d_done); end
    n_vec++; if (d_cnt !== '0) begin n_err++; $display("FAIL reset_count got %0d want 0", d_cnt); end
    n_vec++; if (d_bphit !== 1'b0) begin n_err++; $display("FAIL reset_bphit got %b want 0", d_bphit); end
    rst = 1'b0;
  endtask

  task automatic test_run_halt();
    apply(1, C_RUN, 0);
    n_vec++; if (d_state !== M_RUN || d_en !== 1'b1) begin n_err++; $display("FAIL run_enter got state=%0d en=%b want 1/1", d_state, d_en); end
    for (int i = 0; i < 10; i++) apply(0, C_FLUSH, 0);
    n_vec++; if (d_cnt !== CW'(10)) begin n_err++; $display("FAIL run_count10 got %0d want 10", d_cnt); end
    apply(0, C_FLUSH, 1);
    n_vec++; if (d_state !== M_DONE || d_done !== 1'b1) begin n_err++; $display("FAIL halt_done got state=%0d done=%b want 3/1", d_state, d_done); end
    n_vec++; if (d_cnt !== CW'(11) || d_en !== 1'b0) begin n_err++; $display("FAIL halt_count got cnt=%0d en=%b want 11/0", d_cnt, d_en); end
    apply(0, C_FLUSH, 1);
    n_vec++; if (d_done !== 1'b0 || d_cnt !== CW'(11)) begin n_err++; $display("FAIL halt_pulse_once got done=%b cnt=%0d want 0/11", d_done, d_cnt); end
  endtask

  task automatic test_done_flush();
    apply(1, C_RUN, 0);
    n_vec++; if (d_state !== M_DONE || d_en !== 1'b0 || d_ready !== 1'b1) begin n_err++; $display("FAIL done_ignore_run got state=%0d en=%b rdy=%b want 3/0/1", d_state, d_en, d_ready); end
    apply(1, C_FLUSH, 0);
    n_vec++; if (d_flush !== 1'b1 || d_cnt !== '0 || d_state !== M_IDLE) begin n_err++; $display("FAIL done_flush got flush=%b cnt=%0d state=%0d want 1/0/0", d_flush, d_cnt, d_state); end
    apply(0, C_FLUSH, 0);
    n_vec++; if (d_flush !== 1'b0) begin n_err++; $display("FAIL flush_pulse_once got %b want 0", d_flush); end
  endtask

  task automatic test_step();
    for (int i = 0; i < 3; i++) begin
      apply(1, C_STEP, 0);
      n_vec++; if (d_state !== M_STEP || d_en !== 1'b1 || d_ready !== 1'b0) begin n_err++; $display("FAIL step%0d_active got state=%0d en=%b rdy=%b want 2/1/0", i, d_state, d_en, d_ready); end
      apply(1, C_RUN, 0);
      n_vec++; if (d_state !== M_IDLE || d_done !== 1'b1 || d_en !== 1'b0) begin n_err++; $display("FAIL step%0d_done got state=%0d done=%b en=%b want 0/1/0", i, d_state, d_done, d_en); end
    end
    n_vec++; if (d_cnt !== CW'(3)) begin n_err++; $display("FAIL step_count got %0d want 3", d_cnt); end
  endtask

  task automatic test_stop_halt();
    apply(1, C_RUN, 0);
    apply(0, C_FLUSH, 0);
    apply(1, C_STOP, 1);
    n_vec++; if (d_state !== M_DONE || d_done !== 1'b1) begin n_err++; $display("FAIL stop_halt got state=%0d done=%b want 3/1", d_state, d_done); end
    apply(1, C_FLUSH, 0);
    apply(1, C_RUN, 0);
    apply(1, C_STOP, 0);
    n_vec++; if (d_state !== M_IDLE || d_done !== 1'b0) begin n_err++; $display("FAIL stop_only got state=%0d done=%b want 0/0", d_state, d_done); end
  endtask

  task automatic test_saturate();
    apply(1, C_FLUSH, 0);
    apply(1, C_RUN, 0);
    for (int i = 0; i < 62; i++) apply(0, C_FLUSH, 0);
    n_vec++; if (d_cnt !== CMAX - CW'(1)) begin n_err++; $display("FAIL sat_pre got %0d want %0d", d_cnt, CMAX - CW'(1)); end
    for (int i = 0; i < 3; i++) begin
      apply(0, C_FLUSH, 0);
      n_vec++; if (d_cnt !== CMAX) begin n_err++; $display("FAIL sat_hold%0d got %0d want %0d", i, d_cnt, CMAX); end
    end
    apply(1, C_STOP, 0);
  endtask

  task automatic test_reset_midrun();
    apply(1, C_RUN, 0);
    apply(0, C_FLUSH, 0);
    rst = 1'b1;
    apply(0, C_FLUSH, 0);
    rst = 1'b0;
    n_vec++; if (d_state !== M_IDLE || d_done !== 1'b0 || d_en !== 1'b0 || d_cnt !== '0) begin n_err++; $display("FAIL reset_midrun got state=%0d done=%b en=%b cnt=%0d want 0/0/0/0", d_state, d_done, d_en, d_cnt); end
  endtask

`ifdef EXEC_SEQ_BREAKPOINT_EN
  task automatic test_breakpoint();
    logic en;
    logic hit_seen;
    hit_seen = 1'b0;
    bp_valid = 1'b1;
    bp_addr  = 32'h20;
    pc       = 32'h10;
    apply(1, C_RUN, 0);
    for (int i = 0; i < 20 && !hit_seen; i++) begin
      if (pc == 32'h20) begin
        hit_seen = 1'b1;
        n_vec++; if (d_en !== 1'b0) begin n_err++; $display("FAIL bp_stall got en=%b want 0", d_en); end
        apply(0, C_FLUSH, 0);
        n_vec++; if (d_state !== M_IDLE || d_done !== 1'b1 || d_bphit !== 1'b1) begin n_err++; $display("FAIL bp_stop got state=%0d done=%b hit=%b want 0/1/1", d_state, d_done, d_bphit); end
      end else begin
        n_vec++; if (d_en !== 1'b1) begin n_err++; $display("FAIL bp_run_en pc=%0h got %b want 1", pc, d_en); end
        en = m_en();
        apply(0, C_FLUSH, 0);
        if (en) pc = pc + 32'd4;
      end
    end
    if (!hit_seen) begin n_vec++; n_err++; $display("FAIL bp_timeout got no hit want hit at 0x20"); end
    apply(1, C_RUN, 0);
    n_vec++; if (d_bphit !== 1'b0 || d_en !== 1'b1) begin n_err++; $display("FAIL bp_resume got hit=%b en=%b want 0/1", d_bphit, d_en); end
    apply(0, C_FLUSH, 0);
    pc = pc + 32'd4;
    n_vec++; if (pc !== 32'h24 || d_en !== 1'b1 || d_state !== M_RUN) begin n_err++; $display("FAIL bp_past got pc=%0h en=%b state=%0d want 24/1/1", pc, d_en, d_state); end
    apply(1, C_STOP, 0);
    bp_valid = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
`ifdef EXEC_SEQ_BREAKPOINT_EN
      bp_valid = $urandom_range(0, 1) == 1;
      pc       = ($urandom_range(0, 2) == 0) ? 32'h40 : 32'h44;
`endif
      apply($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
      n_vec++; if (d_state !== ms) begin n_err++; $display("FAIL rnd%0d_state got %0d want %0d", i, d_state, ms); end
      n_vec++; if (d_cnt !== mcnt) begin n_err++; $display("FAIL rnd%0d_count got %0d want %0d", i, d_cnt, mcnt); end
      n_vec++; if (d_flush !== mflush || d_done !== mdone) begin n_err++; $display("FAIL rnd%0d_pulses got flush=%b done=%b want %b/%b", i, d_flush, d_done, mflush, mdone); end
      n_vec++; if (d_en !== m_en() || d_ready !== m_ready()) begin n_err++; $display("FAIL rnd%0d_en_rdy got en=%b rdy=%b want %b/%b", i, d_en, d_ready, m_en(), m_ready()); end
      n_vec++; if (d_bphit !== mbphit) begin n_err++; $display("FAIL rnd%0d_bphit got %b want %b", i, d_bphit, mbphit); end
    end
    rst = 1'b0;
    bp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd = C_FLUSH; halt_ret = 1'b0;
    pc = 32'h0; bp_valid = 1'b0; bp_addr = 32'h0;
    ms = M_IDLE; mcnt = '0; mflush = 0; mdone = 0; mbphit = 0; marmed = 0;
    test_reset();
    test_run_halt();
    test_done_flush();
    test_step();
    test_stop_halt();
    test_saturate();
    test_reset_midrun();
`ifdef EXEC_SEQ_BREAKPOINT_EN
    test_breakpoint();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
